// File: rtl/pipe_wb_lsu.sv
// pipe_wb_lsu -- writeback stage with load-response hold, flush, ID
// forwarding/stall export and a retired-instruction counter.
//
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   ms_valid / ws_allowin           MEM->WB handshake
//   ms_pc, ms_rf_we, ms_rf_waddr,
//   ms_rf_wdata, ms_is_load,
//   ms_ld_op, ms_ld_off             instruction fields latched on accept
//   mem_data_ok, mem_rdata          load response (one pulse per load)
//   flush                           discard the current entry
//   rf_we, rf_waddr, rf_wdata       register-file write port
//   fwd_valid, fwd_pending,
//   fwd_addr, fwd_data              forwarding / stall info for ID
//   instret                         committed instruction count (wraps)
//   wb_pc                           PC of the current entry
//
// Optional: define WB_TRACE_EN to add debug_wb_pc, debug_wb_rf_we,
// debug_wb_rf_wnum and debug_wb_rf_wdata, all zero except on commit cycles.

module pipe_wb_lsu #(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5,
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ms_valid,
  output logic             ws_allowin,
  input  logic [XLEN-1:0]  ms_pc,
  input  logic             ms_rf_we,
  input  logic [RF_AW-1:0] ms_rf_waddr,
  input  logic [XLEN-1:0]  ms_rf_wdata,
  input  logic             ms_is_load,
  input  logic [2:0]       ms_ld_op,
  input  logic [2:0]       ms_ld_off,
  input  logic             mem_data_ok,
  input  logic [XLEN-1:0]  mem_rdata,
  input  logic             flush,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]  rf_wdata,
  output logic             fwd_valid,
  output logic             fwd_pending,
  output logic [RF_AW-1:0] fwd_addr,
  output logic [XLEN-1:0]  fwd_data,
  output logic [CNT_W-1:0] instret,
  output logic [XLEN-1:0]  wb_pc
`ifdef WB_TRACE_EN
  ,
  output logic [XLEN-1:0]   debug_wb_pc,
  output logic [XLEN/8-1:0] debug_wb_rf_we,
  output logic [RF_AW-1:0]  debug_wb_rf_wnum,
  output logic [XLEN-1:0]   debug_wb_rf_wdata
`endif
);

  typedef enum logic [1:0] {S_EMPTY, S_WAIT, S_HOLD, S_DISCARD} state_t;

  state_t           state;
  logic             e_we;
  logic [RF_AW-1:0] e_waddr;
  logic [XLEN-1:0]  e_wdata;
  logic [2:0]       e_ld_op;
  logic [2:0]       e_ld_off;

  logic             commit;
  logic             accept;
  logic             e_writes;
  logic             sx;
  logic [XLEN-1:0]  sel;
  logic [XLEN-1:0]  ld_w;
  logic [XLEN-1:0]  ld_data;

  assign commit     = (state == S_HOLD) && !flush;
  assign ws_allowin = !flush && ((state == S_EMPTY) || (state == S_HOLD));
  assign accept     = ms_valid && ws_allowin;
  assign e_writes   = e_we && (e_waddr != '0);

  assign rf_we       = commit && e_writes;
  assign rf_waddr    = e_waddr;
  assign rf_wdata    = e_wdata;
  assign fwd_valid   = ((state == S_WAIT) || (state == S_HOLD)) && e_writes;
  assign fwd_pending = fwd_valid && (state == S_WAIT);
  assign fwd_addr    = e_waddr;
  assign fwd_data    = e_wdata;

  // Load alignment uses the latched offset/op; the response arrives later.
  assign sel = mem_rdata >> {e_ld_off, 3'b000};
  assign sx  = ~e_ld_op[2];

  // Word extension only exists when the datapath is wider than 32 bits;
  // on a 32-bit datapath a word is the whole register and [2] is moot.
  generate
    if (XLEN > 32) begin : g_wide
      assign ld_w = {{(XLEN-32){sx & sel[31]}}, sel[31:0]};
    end else begin : g_narrow
      assign ld_w = sel;
    end
  endgenerate

  always_comb begin
    ld_data = sel;
    case (e_ld_op[1:0])
      2'd0:    ld_data = {{(XLEN-8){sx & sel[7]}}, sel[7:0]};
      2'd1:    ld_data = {{(XLEN-16){sx & sel[15]}}, sel[15:0]};
      2'd2:    ld_data = ld_w;
      default: ld_data = sel;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_EMPTY;
      e_we     <= 1'b0;
      e_waddr  <= '0;
      e_wdata  <= '0;
      e_ld_op  <= '0;
      e_ld_off <= '0;
      wb_pc    <= '0;
      instret  <= '0;
    end else begin
      if (commit) instret <= instret + CNT_W'(1);
      case (state)
        S_EMPTY, S_HOLD: begin
          if (accept) begin
            e_we     <= ms_rf_we;
            e_waddr  <= ms_rf_waddr;
            e_wdata  <= ms_rf_wdata;
            e_ld_op  <= ms_ld_op;
            e_ld_off <= ms_ld_off;
            wb_pc    <= ms_pc;
            state    <= ms_is_load ? S_WAIT : S_HOLD;
          end else begin
            state <= S_EMPTY;
          end
        end
        S_WAIT: begin
          if (mem_data_ok) begin
            // A flush coinciding with the response retires the load silently.
            state <= flush ? S_EMPTY : S_HOLD;
            if (!flush) e_wdata <= ld_data;
          end else if (flush) begin
            state <= S_DISCARD;
          end
        end
        S_DISCARD: begin
          // Swallow the outstanding response of the flushed load.
          if (mem_data_ok) state <= S_EMPTY;
        end
        default: state <= S_EMPTY;
      endcase
    end
  end

`ifdef WB_TRACE_EN
  assign debug_wb_pc       = commit ? wb_pc : '0;
  assign debug_wb_rf_we    = rf_we ? '1 : '0;
  assign debug_wb_rf_wnum  = commit ? e_waddr : '0;
  assign debug_wb_rf_wdata = commit ? e_wdata : '0;
`endif

endmodule
